// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, queue entry type and count-width helper for
//               the fetch queue unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_BYTES = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_if
// Description : Redirect, instruction-memory and decode handshake signals of
//               the fetch queue unit; master is the fetch unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);

  logic                 jumpFlag_i;
  logic [AddrWidth-1:0] jumpAddr_i;
  logic                 request_o;
  logic [AddrWidth-1:0] instAddr_fetch_o;
  logic                 grant_i;
  logic                 dataOk_i;
  logic [DataWidth-1:0] inst_fetch_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DataWidth-1:0] inst_o;
  logic [AddrWidth-1:0] instAddr_o;

  modport master (
    input  jumpFlag_i, jumpAddr_i, grant_i, dataOk_i, inst_fetch_i, ready_i,
    output request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o
  );

  modport slave (
    output jumpFlag_i, jumpAddr_i, grant_i, dataOk_i, inst_fetch_i, ready_i,
    input  request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush and occupancy count; depth need
//               not be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic      [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Sequential fetch with bounded outstanding requests, an
//               instruction/PC queue to decode and jump redirect with drop of
//               stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                   DataWidth      = DATA_WIDTH,
  parameter int                   AddrWidth      = ADDR_WIDTH,
  parameter int                   Depth          = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] ResetPc        = AddrWidth'(RESET_PC),
  parameter int                   InstBytes      = INST_BYTES
) (
  input wire logic        clk,
  input wire logic        reset,
  fetch_queue_unit_if.master bus
);

  localparam int CNT_W = cnt_width(Depth);
  localparam int OUT_W = cnt_width(MaxOutstanding);

  logic [AddrWidth-1:0]           r_pc;
  logic [OUT_W-1:0]               r_outstanding;
  logic [OUT_W-1:0]               r_discard;

  logic                           w_grant;
  logic                           w_ok;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_credit;
  logic [31:0]                    w_used;
  logic [OUT_W-1:0]               w_out_next;
  logic [OUT_W-1:0]               w_tag_count;
  logic [CNT_W-1:0]               w_fifo_count;
  logic [AddrWidth-1:0]           w_tag_pc;
  logic [DataWidth+AddrWidth-1:0] w_head;

  // Live in-flight requests each own a future queue slot; stale ones do not.
  assign w_used   = 32'(w_fifo_count) + 32'(r_outstanding) - 32'(r_discard);
  assign w_credit = (32'(r_outstanding) < 32'(MaxOutstanding)) && (w_used < 32'(Depth));

  assign bus.request_o = ~reset & ~bus.jumpFlag_i & w_credit;
  assign w_grant       = bus.request_o & bus.grant_i;
  assign w_ok          = bus.dataOk_i & (w_tag_count != '0);
  assign w_push        = w_ok & (r_discard == '0) & ~bus.jumpFlag_i;
  assign w_pop         = bus.valid_o & bus.ready_i;
  assign w_out_next    = r_outstanding + OUT_W'(w_grant) - OUT_W'(w_ok);

  // After a jump every request still in flight is from the old path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= ResetPc;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (bus.jumpFlag_i) begin
        r_pc      <= bus.jumpAddr_i;
        r_discard <= w_out_next;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + AddrWidth'(InstBytes);
        end
        if (w_ok && (r_discard != '0)) begin
          r_discard <= r_discard - OUT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (AddrWidth),
    .DEPTH (MaxOutstanding)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (1'b0),
    .push      (w_grant),
    .push_data (r_pc),
    .pop       (w_ok),
    .pop_data  (w_tag_pc),
    .count     (w_tag_count)
  );

  fetch_fifo #(
    .WIDTH (DataWidth + AddrWidth),
    .DEPTH (Depth)
  ) u_entry_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (bus.jumpFlag_i),
    .push      (w_push),
    .push_data ({bus.inst_fetch_i, w_tag_pc}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_fifo_count)
  );

  assign bus.instAddr_fetch_o        = r_pc;
  assign bus.valid_o                 = (w_fifo_count != '0);
  assign {bus.inst_o, bus.instAddr_o} = w_head;

endmodule
`default_nettype wire
